// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, oversampling ratio and default frame
// parameters, common to the transmitter and the matching receiver.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE  = 2'b00;
  localparam uart_state_t START = 2'b01;
  localparam uart_state_t DATA  = 2'b10;
  localparam uart_state_t STOP  = 2'b11;

  localparam int OVERSAMPLE      = 16;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

  // Bit-counter width that stays at least one bit wide for degenerate DBIT.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read side of a first-word-fall-through byte FIFO, as seen by a consumer
// (master, issues pops) and by the FIFO itself (slave).
interface uart_tx_fifo_drain_if
  import uart_pkg::*;
#(
  parameter int DBIT = DEFAULT_DBIT
);

  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_rd
  );

endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter that drains an upstream FWFT FIFO, one pop per frame,
// timed by an external 16x oversampling tick.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  uart_tx_fifo_drain_if.master fifo,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int              NW        = cnt_width(DBIT);
  localparam logic [5:0]      S_LAST    = 6'(OVERSAMPLE - 1);
  localparam logic [5:0]      STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);

  uart_state_t     state, state_next;
  logic [5:0]      s_cnt, s_cnt_next;
  logic [NW-1:0]   n_cnt, n_cnt_next;
  logic [DBIT-1:0] shift, shift_next;
  logic            tx_reg, tx_next;
  logic            pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      shift  <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_next;
      s_cnt  <= s_cnt_next;
      n_cnt  <= n_cnt_next;
      shift  <= shift_next;
      tx_reg <= tx_next;
    end
  end

  // Pop is gated by reset so the FIFO is never drained while the block is held.
  always_comb begin
    state_next   = state;
    s_cnt_next   = s_cnt;
    n_cnt_next   = n_cnt;
    shift_next   = shift;
    pop          = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo.fifo_empty && reset) begin
          pop        = 1'b1;
          shift_next = fifo.fifo_r_data;
          s_cnt_next = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
            state_next = DATA;
          end else begin
            s_cnt_next = s_cnt + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_next = '0;
            shift_next = shift >> 1;
            if (n_cnt == N_LAST) begin
              state_next = STOP;
            end else begin
              n_cnt_next = n_cnt + NW'(1);
            end
          end else begin
            s_cnt_next = s_cnt + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            s_cnt_next = s_cnt + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed for the upcoming state so tx can be a plain flop.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign fifo.fifo_rd = pop;
  assign tx           = tx_reg;
  assign tx_busy      = (state != IDLE) || pop;

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Transmit end of the serial debug path: reads bytes from the read side of an upstream byte FIFO (rd/empty/r_data) and serializes each one as an 8N1 UART frame on tx.
- Oversampled-tick based: a 16x baud tick (s_tick) comes from the external baud-rate generator.
- Pops one word per frame. Never pops while a frame is in flight.

Parameters:
- DBIT, 8, data bits per frame, sent LSB first.
- SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2). Legal range 16..32.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk pulse at 16x baud rate.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_r_data  input  DBIT  upstream FIFO head word. Valid combinationally whenever fifo_empty=0 (first-word-fall-through).
- fifo_rd  output  1  one-cycle pop strobe to the upstream FIFO.
- tx  output  1  serial line. Idle level is 1.
- tx_busy  output  1  high from the pop cycle until the end of the stop period.
- tx_done_tick  output  1  one-clk pulse when the stop period completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, s_cnt=0, n_cnt=0, shift=0.
  - tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, all immediately.
  - A frame in flight is abandoned with no pop and no done pulse.
- Registered state: state (2b), s_cnt (6b, tick counter), n_cnt (clog2(DBIT) bits), shift (DBIT), tx_reg. tx is driven from tx_reg, so it is glitch-free.
- IDLE:
  - tx=1.
  - If fifo_empty=0: fifo_rd=1 for this cycle only, shift<=fifo_r_data, s_cnt<=0, go to START.
  - fifo_rd is combinational and is asserted only in IDLE with fifo_empty=0. It is never asserted when fifo_empty=1.
- START:
  - tx=0.
  - On each s_tick: if s_cnt==15 then s_cnt<=0, n_cnt<=0, go to DATA; else s_cnt++.
- DATA:
  - tx=shift[0].
  - On each s_tick: if s_cnt==15 then s_cnt<=0 and shift<=shift>>1. If n_cnt==DBIT-1 go to STOP, else n_cnt++. Otherwise s_cnt++.
- STOP:
  - tx=1.
  - On each s_tick: if s_cnt==SB_TICK-1 then tx_done_tick=1 for this cycle and go to IDLE; else s_cnt++.
- Without s_tick the FSM holds state and counters. With s_tick stuck low, tx holds its current level indefinitely.
- Frame length is exactly 16*(1+DBIT)+SB_TICK s_tick pulses from the first tick after the pop. The start edge occurs the clk after the pop cycle.
- Back-to-back frames: after a done cycle the block spends exactly one clk in IDLE (tx=1). In that IDLE cycle it pops the next word if fifo_empty=0. There are no extra idle bit-times beyond that one clk.
- Data is captured only at pop time. Later changes on fifo_r_data mid-frame have no effect on the frame.
- tx_busy = (state != IDLE) or fifo_rd.

Decomposition:
- Shared package `uart_pkg` holds:
  - state encodings IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - the OVERSAMPLE=16 constant;
  - default DBIT/SB_TICK.
  The matching receiver uses the same package.
- No sub-module. The baud tick generator stays a separate top-level instance shared with the receiver.

Test Plan:
- Reset: hold reset=0 with fifo_empty=0 -> tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0 throughout. After release, the first pop happens on the first clk.
- Single byte 0xA5, s_tick every cycle:
  - fifo_rd is high exactly 1 clk.
  - tx shows 0 for 16 clk, then bits 1,0,1,0,0,1,0,1 for 16 clk each, then 1 for 16 clk.
  - tx_done_tick pulses at clk 160 after the pop.
- Back-to-back 0x00 then 0xFF, FIFO preloaded, s_tick every 4 clk:
  - two pops;
  - exactly 1 clk of IDLE between the end of the first stop period and the second pop;
  - second frame data bits are all 1.
- Tick stall: drop s_tick for 200 clk during DATA bit 3 -> tx, n_cnt and s_cnt all frozen. The remaining bits resume correctly and the frame still totals 160 ticks.
- Reset mid-frame: assert reset during DATA -> tx=1 asynchronously and no tx_done_tick. After release with fifo_empty=0, a new pop starts a fresh frame from the next FIFO word.
- SB_TICK=32, byte 0x3C -> the stop period lasts 32 ticks and tx_done_tick fires after 176 ticks. An empty FIFO afterwards produces no fifo_rd.
